// File: rtl/stage3_mem_access_unit.sv
// Memory stage of the 3-stage pipeline: data-bus handshake, store lane steering, load alignment, writeback mux.
// Optional performance counters are enabled by defining STAGE3_MEM_ACCESS_COUNTERS_EN.
module stage3_mem_access_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_m,
    input  logic        dren_m,
    input  logic        dwen_m,
    input  logic        reg_write_m,
    input  logic [4:0]  rd_m,
    input  logic [1:0]  w_sel_m,
    input  logic [2:0]  load_type_m,
    input  logic [31:0] port_out_m,
    input  logic [31:0] rs2_data_m,
    input  logic [31:0] pc4_m,
    input  logic [31:0] imm_U_m,
    input  logic        stall_other,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_busy,
    output logic        dbus_ren,
    output logic        dbus_wen,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_byte_en,
    output logic        mem_stall,
    output logic        reg_write,
    output logic [4:0]  rd,
    output logic [31:0] reg_wdata,
    output logic        mal_load,
    output logic        mal_store
`ifdef STAGE3_MEM_ACCESS_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t      state;
    logic [31:0] data_q;
    logic [1:0]  off;
    logic        misaligned;
    logic        mem_op;
    logic        request;
    logic        complete;
    logic [31:0] load_word;
    logic [31:0] load_shift;
    logic [31:0] half_shift;
    logic [31:0] load_data;

    assign off = port_out_m[1:0];

    // Alignment only matters for memory ops; ALU results with odd values must still write back.
    always_comb begin
        misaligned = 1'b0;
        if (dren_m | dwen_m) begin
            unique case (load_type_m[1:0])
                2'd1:    misaligned = port_out_m[0];
                2'd2:    misaligned = (off != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end
    end

    assign mal_load  = valid_m & dren_m & misaligned;
    assign mal_store = valid_m & dwen_m & misaligned;
    assign mem_op    = valid_m & (dren_m | dwen_m) & ~misaligned;
    assign request   = mem_op & (state != DONE) & ~RST;
    assign complete  = request & ~dbus_busy;

    assign dbus_ren  = dren_m & request;
    assign dbus_wen  = dwen_m & request;
    assign dbus_addr = {port_out_m[31:2], 2'b00};
    assign mem_stall = request & dbus_busy;

    always_comb begin
        dbus_byte_en = 4'b1111;
        dbus_wdata   = rs2_data_m;
        unique case (load_type_m[1:0])
            2'd0: begin
                dbus_byte_en = 4'b0001 << off;
                dbus_wdata   = {4{rs2_data_m[7:0]}};
            end
            2'd1: begin
                dbus_byte_en = 4'b0011 << off;
                dbus_wdata   = {2{rs2_data_m[15:0]}};
            end
            default: begin
                dbus_byte_en = 4'b1111;
                dbus_wdata   = rs2_data_m;
            end
        endcase
    end

    // Once parked in DONE the bus word is gone, so the latched copy feeds writeback.
    assign load_word  = (state == DONE) ? data_q : dbus_rdata;
    assign load_shift = load_word >> {off, 3'b000};
    assign half_shift = load_word >> {off[1], 4'b0000};

    always_comb begin
        unique case (load_type_m)
            3'd0:    load_data = {{24{load_shift[7]}}, load_shift[7:0]};
            3'd1:    load_data = {{16{half_shift[15]}}, half_shift[15:0]};
            3'd4:    load_data = {24'd0, load_shift[7:0]};
            3'd5:    load_data = {16'd0, half_shift[15:0]};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        unique case (w_sel_m)
            2'd0:    reg_wdata = load_data;
            2'd1:    reg_wdata = pc4_m;
            2'd2:    reg_wdata = imm_U_m;
            default: reg_wdata = port_out_m;
        endcase
    end

    assign rd        = rd_m;
    assign reg_write = valid_m & reg_write_m & ~misaligned & ~(dren_m & mem_stall);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            data_q <= '0;
        end else begin
            if (complete) data_q <= dbus_rdata;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        if (dbus_busy)        state <= ACCESS;
                        else if (stall_other) state <= DONE;
                    end
                end
                ACCESS: begin
                    if (!mem_op)         state <= IDLE;
                    else if (!dbus_busy) state <= stall_other ? DONE : IDLE;
                end
                DONE: begin
                    if (!stall_other) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STAGE3_MEM_ACCESS_COUNTERS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            load_cnt      <= '0;
            store_cnt     <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if (complete & dren_m) load_cnt      <= load_cnt + 1'b1;
            if (complete & dwen_m) store_cnt     <= store_cnt + 1'b1;
            if (mem_stall)         mem_stall_cnt <= mem_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stage3_mem_access_unit.sv
// Self-checking bench for stage3_mem_access_unit: vector table through a scoreboard plus multi-cycle sequences.
module tb_stage3_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        valid_m, dren_m, dwen_m, reg_write_m, stall_other, dbus_busy;
    logic [4:0]  rd_m;
    logic [1:0]  w_sel_m;
    logic [2:0]  load_type_m;
    logic [31:0] port_out_m, rs2_data_m, pc4_m, imm_U_m, dbus_rdata;
    logic        dbus_ren, dbus_wen, mem_stall, reg_write, mal_load, mal_store;
    logic [31:0] dbus_addr, dbus_wdata, reg_wdata;
    logic [3:0]  dbus_byte_en;
    logic [4:0]  rd;
`ifdef STAGE3_MEM_ACCESS_COUNTERS_EN
    logic [31:0] load_cnt, store_cnt, mem_stall_cnt;
`endif

    stage3_mem_access_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .valid_m(valid_m), .dren_m(dren_m), .dwen_m(dwen_m),
        .reg_write_m(reg_write_m), .rd_m(rd_m), .w_sel_m(w_sel_m), .load_type_m(load_type_m),
        .port_out_m(port_out_m), .rs2_data_m(rs2_data_m), .pc4_m(pc4_m), .imm_U_m(imm_U_m),
        .stall_other(stall_other), .dbus_rdata(dbus_rdata), .dbus_busy(dbus_busy),
        .dbus_ren(dbus_ren), .dbus_wen(dbus_wen), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_byte_en(dbus_byte_en), .mem_stall(mem_stall), .reg_write(reg_write), .rd(rd),
        .reg_wdata(reg_wdata), .mal_load(mal_load), .mal_store(mal_store)
`ifdef STAGE3_MEM_ACCESS_COUNTERS_EN
        , .load_cnt(load_cnt), .store_cnt(store_cnt), .mem_stall_cnt(mem_stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        dren, dwen, rw;
        logic [1:0]  wsel;
        logic [2:0]  lt;
        logic [31:0] addr, rs2, rdata;
        logic        e_ren, e_wen;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rw;
        logic [31:0] e_wd;
        logic        e_mall, e_mals;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic dren, input logic dwen, input logic rw,
                                input logic [1:0] wsel, input logic [2:0] lt, input logic [31:0] addr,
                                input logic [31:0] rs2, input logic [31:0] rdata, input logic e_ren,
                                input logic e_wen, input logic [3:0] e_be, input logic [31:0] e_wdata,
                                input logic e_rw, input logic [31:0] e_wd, input logic e_mall,
                                input logic e_mals);
        vec_t v;
        v.name = name; v.dren = dren; v.dwen = dwen; v.rw = rw; v.wsel = wsel; v.lt = lt;
        v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.e_ren = e_ren; v.e_wen = e_wen;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_rw = e_rw; v.e_wd = e_wd;
        v.e_mall = e_mall; v.e_mals = e_mals;
        return v;
    endfunction

    task automatic idle_inputs();
        valid_m = 0; dren_m = 0; dwen_m = 0; reg_write_m = 0; rd_m = 0; w_sel_m = 0;
        load_type_m = 0; port_out_m = 0; rs2_data_m = 0; stall_other = 0;
        dbus_rdata = 0; dbus_busy = 0;
    endtask

    task automatic drive_lw(input logic [31:0] addr);
        valid_m = 1; dren_m = 1; dwen_m = 0; reg_write_m = 1; rd_m = 5'd7;
        w_sel_m = 2'd0; load_type_m = 3'd2; port_out_m = addr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        pc4_m = 32'h0000_1004;
        imm_U_m = 32'hABCD_E000;
        idle_inputs();
        RST = 1;

        //          name        dren dwen rw  wsel  lt    addr   rs2          rdata         ren wen be       wdata         rw  wd            mall mals
        vecs.push_back(mk("lb_sext",  1, 0, 1, 2'd0, 3'd0, 'h203, 0,            'h8012_3456, 1, 0, 4'b1000, 0,            1, 'hFFFF_FF80, 0, 0));
        vecs.push_back(mk("lbu",      1, 0, 1, 2'd0, 3'd4, 'h203, 0,            'h8012_3456, 1, 0, 4'b1000, 0,            1, 'h0000_0080, 0, 0));
        vecs.push_back(mk("sh",       0, 1, 0, 2'd0, 3'd1, 'h102, 'h1234_ABCD, 0,            0, 1, 4'b1100, 'hABCD_ABCD, 0, 0,            0, 0));
        vecs.push_back(mk("lw_mal",   1, 0, 1, 2'd0, 3'd2, 'h101, 0,            'h1111_1111, 0, 0, 4'b1111, 0,            0, 0,            1, 0));
        vecs.push_back(mk("alu",      0, 0, 1, 2'd3, 3'd0, 'h055, 0,            0,            0, 0, 4'b0010, 0,            1, 'h0000_0055, 0, 0));
        vecs.push_back(mk("pc4",      0, 0, 1, 2'd1, 3'd2, 'h000, 0,            0,            0, 0, 4'b1111, 0,            1, 'h0000_1004, 0, 0));
        vecs.push_back(mk("immu",     0, 0, 1, 2'd2, 3'd2, 'h000, 0,            0,            0, 0, 4'b1111, 0,            1, 'hABCD_E000, 0, 0));
        vecs.push_back(mk("lh_sext",  1, 0, 1, 2'd0, 3'd1, 'h202, 0,            'h8001_0000, 1, 0, 4'b1100, 0,            1, 'hFFFF_8001, 0, 0));
        vecs.push_back(mk("lhu",      1, 0, 1, 2'd0, 3'd5, 'h202, 0,            'h8001_0000, 1, 0, 4'b1100, 0,            1, 'h0000_8001, 0, 0));
        vecs.push_back(mk("sb",       0, 1, 0, 2'd0, 3'd0, 'h101, 'h0000_00AB, 0,            0, 1, 4'b0010, 'hABAB_ABAB, 0, 0,            0, 0));
        vecs.push_back(mk("sw_mal",   0, 1, 0, 2'd0, 3'd2, 'h102, 'h5555_5555, 0,            0, 0, 4'b1111, 0,            0, 0,            0, 1));
        vecs.push_back(mk("sw",       0, 1, 0, 2'd0, 3'd2, 'h100, 'hCAFE_F00D, 0,            0, 1, 4'b1111, 'hCAFE_F00D, 0, 0,            0, 0));
        vecs.push_back(mk("lh_mal",   1, 0, 1, 2'd0, 3'd1, 'h201, 0,            'h2222_2222, 0, 0, 4'b0110, 0,            0, 0,            1, 0));
        vecs.push_back(mk("lw_ok",    1, 0, 1, 2'd0, 3'd2, 'h204, 0,            'h1357_9BDF, 1, 0, 4'b1111, 0,            1, 'h1357_9BDF, 0, 0));
        vecs.push_back(mk("lb_off1",  1, 0, 1, 2'd0, 3'd0, 'h201, 0,            'h0000_7F00, 1, 0, 4'b0010, 0,            1, 'h0000_007F, 0, 0));

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_state", 32'(dut.state), 0);
        chk("rst_ren", 32'(dbus_ren), 0);
        RST = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge CLK); #1;
            valid_m = 1; dren_m = vecs[i].dren; dwen_m = vecs[i].dwen; reg_write_m = vecs[i].rw;
            rd_m = 5'(i + 1); w_sel_m = vecs[i].wsel; load_type_m = vecs[i].lt;
            port_out_m = vecs[i].addr; rs2_data_m = vecs[i].rs2; dbus_rdata = vecs[i].rdata;
            dbus_busy = 0; stall_other = 0;
            exp_q.push_back(vecs[i]);
            @(negedge CLK);
            e = exp_q.pop_front();
            chk({e.name, ".ren"},  32'(dbus_ren), 32'(e.e_ren));
            chk({e.name, ".wen"},  32'(dbus_wen), 32'(e.e_wen));
            chk({e.name, ".be"},   32'(dbus_byte_en), 32'(e.e_be));
            chk({e.name, ".addr"}, dbus_addr, e.addr & 32'hFFFF_FFFC);
            if (e.e_wen) chk({e.name, ".wdata"}, dbus_wdata, e.e_wdata);
            chk({e.name, ".rw"},   32'(reg_write), 32'(e.e_rw));
            if (e.e_rw) chk({e.name, ".wd"}, reg_wdata, e.e_wd);
            chk({e.name, ".rd"},   32'(rd), 32'(i + 1));
            chk({e.name, ".mall"}, 32'(mal_load), 32'(e.e_mall));
            chk({e.name, ".mals"}, 32'(mal_store), 32'(e.e_mals));
            chk({e.name, ".stall"}, 32'(mem_stall), 0);
        end

        // LW with three busy cycles before completion
        @(posedge CLK); #1;
        idle_inputs();
        drive_lw(32'h100);
        dbus_busy = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("lw_wait.ren", 32'(dbus_ren), 1);
            chk("lw_wait.addr", dbus_addr, 32'h100);
            chk("lw_wait.stall", 32'(mem_stall), 1);
            chk("lw_wait.rw", 32'(reg_write), 0);
            @(posedge CLK); #1;
        end
        dbus_busy = 0; dbus_rdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("lw_done.ren", 32'(dbus_ren), 1);
        chk("lw_done.stall", 32'(mem_stall), 0);
        chk("lw_done.rw", 32'(reg_write), 1);
        chk("lw_done.wd", reg_wdata, 32'hDEAD_BEEF);
        @(posedge CLK); #1;
        idle_inputs();
        chk("lw_done.state", 32'(dut.state), 0);

        // Completion while the pipeline is held elsewhere
        drive_lw(32'h104);
        stall_other = 1; dbus_rdata = 32'h1122_3344;
        @(negedge CLK);
        chk("hold.ren0", 32'(dbus_ren), 1);
        chk("hold.wd0", reg_wdata, 32'h1122_3344);
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            dbus_rdata = 32'h0BAD_0BAD;
            @(negedge CLK);
            chk("hold.state", 32'(dut.state), 2);
            chk("hold.ren", 32'(dbus_ren), 0);
            chk("hold.stall", 32'(mem_stall), 0);
            chk("hold.rw", 32'(reg_write), 1);
            chk("hold.wd", reg_wdata, 32'h1122_3344);
        end
        @(posedge CLK); #1;
        stall_other = 0;
        @(negedge CLK);
        chk("release.ren", 32'(dbus_ren), 0);
        chk("release.wd", reg_wdata, 32'h1122_3344);
        @(posedge CLK); #1;
        idle_inputs();
        chk("release.state", 32'(dut.state), 0);

        // Reset during an outstanding access
        drive_lw(32'h108);
        dbus_busy = 1;
        @(negedge CLK);
        chk("rst_mid.ren_pre", 32'(dbus_ren), 1);
        @(posedge CLK); #1;
        chk("rst_mid.access", 32'(dut.state), 1);
        RST = 1;
        #1;
        chk("rst_mid.ren", 32'(dbus_ren), 0);
        chk("rst_mid.stall", 32'(mem_stall), 0);
        @(posedge CLK); #1;
        chk("rst_mid.state", 32'(dut.state), 0);
`ifdef STAGE3_MEM_ACCESS_COUNTERS_EN
        chk("rst_mid.load_cnt", load_cnt, 0);
        chk("rst_mid.store_cnt", store_cnt, 0);
        chk("rst_mid.stall_cnt", mem_stall_cnt, 0);
`endif
        RST = 0;
        idle_inputs();
        @(posedge CLK); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
